uart_frame_deframer: RTL and testbench
======================================

# uart_frame_deframer

Store-and-forward packet deframer sitting directly downstream of the AXI-Stream UART receive path. It consumes the received byte stream and the UART receiver's `rx_idle` flag, hunts for a sync byte, validates length and checksum, and releases only intact payloads as AXI-Stream packets with `tlast`. Corrupt, oversize or truncated frames are dropped and counted, so downstream command logic never sees partial data.

## Interface
Parameters:
- `MAX_LEN`, 16: maximum payload bytes per frame (1..255); sets the internal buffer depth.
- `SYNC_BYTE`, 8'hA5: frame start marker.

Ports:
- `aclk` in 1: single clock; all logic on its rising edge.
- `aresetn` in 1: reset, asynchronous, active-low.
- `s_axis_tdata` in 8: received byte from the UART receive FIFO.
- `s_axis_tvalid` in 1: byte valid.
- `s_axis_tready` out 1: byte accepted when `tvalid & tready`.
- `rx_idle` in 1: UART line idle flag (level; high after 16 bit-times without a received byte).
- `m_axis_tdata` out 8: payload byte.
- `m_axis_tvalid` out 1: payload valid.
- `m_axis_tready` in 1: downstream ready.
- `m_axis_tlast` out 1: high with the last payload byte of a frame.
- `frame_ok` out 1: one-cycle pulse when a frame passes checksum.
- `frame_err` out 2: one-cycle pulse code {len_err, csum_err}; 2'b11 = timeout.
- `drop_cnt` out 8: saturating count of dropped frames.

## Operation
- Frame format: SYNC, LEN (1..MAX_LEN), LEN payload bytes, CSUM. Valid when (LEN + sum(payload) + CSUM) mod 256 == 0, using an 8-bit wrapping accumulator.
- States:
  - HUNT: accept bytes, discard any byte other than SYNC_BYTE; on SYNC go to LEN.
  - LEN: LEN == 0 or LEN > MAX_LEN -> `frame_err`=2'b10, drop, HUNT. Otherwise latch LEN, seed the accumulator with LEN, clear the write index, go to PAYLOAD.
  - PAYLOAD: write the byte to `buf[idx]`, add it to the accumulator, increment `idx`; after byte LEN go to CSUM.
  - CSUM: if the sum is zero -> `frame_ok`, go to DRAIN; else `frame_err`=2'b01, drop, HUNT.
  - DRAIN: present `buf[0..LEN-1]` on `m_axis`, then HUNT.
- `s_axis_tready` = 1 in HUNT/LEN/PAYLOAD/CSUM and 0 in DRAIN; it is 0 while `aresetn` is low. Upstream bytes wait in the UART FIFO during DRAIN.
- Timeout: in LEN, PAYLOAD or CSUM, if `rx_idle` = 1 and `s_axis_tvalid` = 0 in the same cycle -> `frame_err`=2'b11, drop, HUNT. `rx_idle` is ignored in HUNT and DRAIN, and whenever a byte is pending.
- A SYNC_BYTE value seen inside LEN, PAYLOAD or CSUM is treated as data, with no resync.
- Every drop increments `drop_cnt`, saturating at 255.
- A drop never touches the buffer contents or `m_axis`.

## Timing
- Reset (async assert, sync release) values: state HUNT, `s_axis_tready` 0 while in reset and 1 on the first cycle after release; `m_axis_tvalid` 0, `m_axis_tlast` 0, `m_axis_tdata` 0, `frame_ok` 0, `frame_err` 0, `drop_cnt` 0.
- Throughput: one input byte per cycle in all accepting states.
- `frame_ok` and `frame_err` are registered, asserted the cycle after the deciding byte is accepted, and last exactly one cycle.
- `m_axis_tvalid` rises the cycle after the CSUM byte is accepted, in the same cycle as `frame_ok`.
- `m_axis_tdata` and `m_axis_tlast` are registered and held stable while `tvalid & ~tready`. The read index advances only on the handshake.
- After the handshake with `tlast` = 1, `m_axis_tvalid` drops and `s_axis_tready` returns to 1 on the next cycle.
- Minimum frame-to-frame gap: one cycle.
- Reset mid-frame or mid-DRAIN aborts immediately: the partial packet is discarded and not counted.

## Test plan
- Good frame: input A5 03 11 22 33 97 with `m_axis_tready` = 1 -> output 11, 22, 33 with `tlast` on 33; `frame_ok` pulses once; `drop_cnt` = 0.
- Bad checksum and length: A5 03 11 22 33 98 -> `frame_err`=01, no output, `drop_cnt`=1. Then A5 00 -> `frame_err`=10. Then A5 11 with MAX_LEN=16 -> `frame_err`=10; `drop_cnt`=3.
- Garbage and data-SYNC: 00 FF 5A A5 02 A5 01 58 -> output A5, 01 with `tlast` on 01; leading garbage produces no error.
- Timeout: A5 04 01 02, then `tvalid`=0 and `rx_idle`=1 -> `frame_err`=11, `drop_cnt`+1. A following good frame is delivered intact.
- Backpressure: good 4-byte frame with `m_axis_tready` toggled 1010… -> data held stable while stalled, 4 handshakes, `s_axis_tready`=0 throughout DRAIN. 300 bad frames -> `drop_cnt` saturates at 255.
- Reset mid-DRAIN: assert `aresetn`=0 after 2 of 4 bytes -> `m_axis_tvalid` drops asynchronously. After release, state is HUNT and the next good frame is output correctly.

Source files
------------

// File: rtl/uart_frame_deframer_if.sv
// Byte-wide AXI-Stream link used on both sides of the deframer.
//   tdata  : payload byte
//   tvalid : byte valid (master -> slave)
//   tready : byte accepted on tvalid & tready (slave -> master)
//   tlast  : last byte of a packet (master -> slave)
interface uart_frame_deframer_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/uart_frame_deframer.sv
// Store-and-forward packet deframer behind a UART receive FIFO.
// Hunts for SYNC_BYTE, checks LEN and an 8-bit wrapping checksum, buffers the payload and only
// releases intact frames downstream. Bad, oversize or timed-out frames are dropped and counted.
//   aclk, aresetn : clock, asynchronous active-low reset
//   s_axis        : received byte stream (tlast unused)
//   m_axis        : validated payload packets with tlast
//   rx_idle       : UART line idle level, used as a mid-frame timeout
//   frame_ok      : one-cycle pulse when a frame passes its checksum
//   frame_err     : one-cycle pulse {len_err, csum_err}; 2'b11 = timeout
//   drop_cnt      : saturating count of dropped frames
module uart_frame_deframer #(
    parameter int unsigned MAX_LEN   = 16,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    uart_frame_deframer_if.slave         s_axis,
    uart_frame_deframer_if.master        m_axis,
    input  logic                         rx_idle,
    output logic                         frame_ok,
    output logic [1:0]                   frame_err,
    output logic [7:0]                   drop_cnt
);
    localparam int unsigned IdxW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {StHunt, StLen, StPayload, StCsum, StDrain} state_e;

    state_e            state_q, state_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        acc_q, acc_d;
    logic [IdxW-1:0]   wr_idx_q, wr_idx_d;
    logic [IdxW-1:0]   rd_idx_q, rd_idx_d;
    logic [7:0]        m_tdata_q, m_tdata_d;
    logic              m_tvalid_q, m_tvalid_d;
    logic              m_tlast_q, m_tlast_d;
    logic              frame_ok_q, frame_ok_d;
    logic [1:0]        frame_err_q, frame_err_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;
    logic [7:0]        buf_q [MAX_LEN];

    logic              in_ready, accept, timeout, drop, buf_we;
    logic [7:0]        acc_sum, last_idx;

    // Ready is forced low during reset, independent of the state register.
    assign in_ready      = aresetn && (state_q != StDrain);
    assign s_axis.tready = in_ready;
    assign accept        = s_axis.tvalid && in_ready;
    // A pending byte always wins over the idle flag.
    assign timeout       = rx_idle && !s_axis.tvalid;
    assign acc_sum       = acc_q + s_axis.tdata;
    assign last_idx      = len_q - 8'd1;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        acc_d       = acc_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        m_tdata_d   = m_tdata_q;
        m_tvalid_d  = m_tvalid_q;
        m_tlast_d   = m_tlast_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 2'b00;
        drop        = 1'b0;
        buf_we      = 1'b0;

        unique case (state_q)
            StHunt: begin
                if (accept && (s_axis.tdata == SYNC_BYTE)) begin
                    state_d = StLen;
                end
            end
            StLen: begin
                if (timeout) begin
                    frame_err_d = 2'b11;
                    drop        = 1'b1;
                    state_d     = StHunt;
                end else if (accept) begin
                    if ((s_axis.tdata == 8'd0) || (s_axis.tdata > 8'(MAX_LEN))) begin
                        frame_err_d = 2'b10;
                        drop        = 1'b1;
                        state_d     = StHunt;
                    end else begin
                        len_d    = s_axis.tdata;
                        acc_d    = s_axis.tdata;
                        wr_idx_d = '0;
                        state_d  = StPayload;
                    end
                end
            end
            StPayload: begin
                if (timeout) begin
                    frame_err_d = 2'b11;
                    drop        = 1'b1;
                    state_d     = StHunt;
                end else if (accept) begin
                    buf_we   = 1'b1;
                    acc_d    = acc_sum;
                    wr_idx_d = wr_idx_q + IdxW'(1);
                    if (8'(wr_idx_q) == last_idx) begin
                        state_d = StCsum;
                    end
                end
            end
            StCsum: begin
                if (timeout) begin
                    frame_err_d = 2'b11;
                    drop        = 1'b1;
                    state_d     = StHunt;
                end else if (accept) begin
                    if (acc_sum == 8'd0) begin
                        // Preload the first payload byte so tvalid rises with frame_ok.
                        frame_ok_d = 1'b1;
                        m_tvalid_d = 1'b1;
                        m_tdata_d  = buf_q[0];
                        m_tlast_d  = (len_q == 8'd1);
                        rd_idx_d   = IdxW'(1);
                        state_d    = StDrain;
                    end else begin
                        frame_err_d = 2'b01;
                        drop        = 1'b1;
                        state_d     = StHunt;
                    end
                end
            end
            StDrain: begin
                if (m_tvalid_q && m_axis.tready) begin
                    if (m_tlast_q) begin
                        m_tvalid_d = 1'b0;
                        m_tlast_d  = 1'b0;
                        state_d    = StHunt;
                    end else begin
                        m_tdata_d = buf_q[rd_idx_q];
                        m_tlast_d = (8'(rd_idx_q) == last_idx);
                        rd_idx_d  = rd_idx_q + IdxW'(1);
                    end
                end
            end
            default: state_d = StHunt;
        endcase

        drop_cnt_d = (drop && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= StHunt;
            len_q       <= 8'd0;
            acc_q       <= 8'd0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            m_tdata_q   <= 8'd0;
            m_tvalid_q  <= 1'b0;
            m_tlast_q   <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 2'b00;
            drop_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            acc_q       <= acc_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            m_tdata_q   <= m_tdata_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tlast_q   <= m_tlast_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Payload storage needs no reset; it is only read after being written by a frame.
    always_ff @(posedge aclk) begin
        if (buf_we) begin
            buf_q[wr_idx_q] <= s_axis.tdata;
        end
    end

    assign m_axis.tdata  = m_tdata_q;
    assign m_axis.tvalid = m_tvalid_q;
    assign m_axis.tlast  = m_tlast_q;
    assign frame_ok      = frame_ok_q;
    assign frame_err     = frame_err_q;
    assign drop_cnt      = drop_cnt_q;
endmodule

// File: tb/tb_uart_frame_deframer.sv
// Directed bench for uart_frame_deframer: inputs change 1 time unit after the rising edge,
// outputs are observed on the falling edge or 1 unit after the rising edge.
module tb_uart_frame_deframer;
    logic       aclk;
    logic       aresetn;
    logic       rx_idle;
    logic       frame_ok;
    logic [1:0] frame_err;
    logic [7:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0] out_q[$];
    logic       last_q[$];
    logic [1:0] err_q[$];
    int         ok_cnt = 0;

    uart_frame_deframer_if s_if ();
    uart_frame_deframer_if m_if ();

    uart_frame_deframer #(
        .MAX_LEN   (16),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s_axis    (s_if),
        .m_axis    (m_if),
        .rx_idle   (rx_idle),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .drop_cnt  (drop_cnt)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Record downstream handshakes and status pulses.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (m_if.tvalid && m_if.tready) begin
                out_q.push_back(m_if.tdata);
                last_q.push_back(m_if.tlast);
            end
            if (frame_ok) ok_cnt++;
            if (frame_err != 2'b00) err_q.push_back(frame_err);
        end
    end

    task automatic clear_log();
        out_q.delete();
        last_q.delete();
        err_q.delete();
        ok_cnt = 0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    // Returns 1 time unit after the edge on which the byte was accepted.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        s_if.tdata  = b;
        s_if.tvalid = 1'b1;
        @(negedge aclk);
        while (!s_if.tready && n < 200) begin
            @(negedge aclk);
            n++;
        end
        if (!s_if.tready) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout got tready=%b required 1", s_if.tready);
        end
        @(posedge aclk);
        #1;
        s_if.tvalid = 1'b0;
    endtask

    task automatic test_reset();
        aresetn     = 1'b0;
        rx_idle     = 1'b0;
        s_if.tdata  = 8'h00;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        cycles(3);
        checks++;
        if (s_if.tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_s_tready got %b required 0", s_if.tready);
        end
        checks++;
        if ({m_if.tvalid, m_if.tlast, m_if.tdata} !== 10'd0) begin
            errors++;
            $display("FAIL reset_m_axis got v=%b l=%b d=%h required 0 0 00",
                     m_if.tvalid, m_if.tlast, m_if.tdata);
        end
        checks++;
        if ({frame_ok, frame_err, drop_cnt} !== 11'd0) begin
            errors++;
            $display("FAIL reset_status got ok=%b err=%b cnt=%0d required 0 00 0",
                     frame_ok, frame_err, drop_cnt);
        end
        aresetn = 1'b1;
        #1;
        checks++;
        if (s_if.tready !== 1'b1) begin
            errors++;
            $display("FAIL release_s_tready got %b required 1", s_if.tready);
        end
        cycles(1);
    endtask

    task automatic test_good_frame();
        logic [7:0] exp_d[$];
        logic       exp_l[$];
        exp_d = '{8'h11, 8'h22, 8'h33};
        exp_l = '{1'b0, 1'b0, 1'b1};
        clear_log();
        m_if.tready = 1'b1;
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h97);
        checks++;
        if ({frame_ok, m_if.tvalid, m_if.tdata, s_if.tready} !== {1'b1, 1'b1, 8'h11, 1'b0}) begin
            errors++;
            $display("FAIL good_first_cycle got ok=%b v=%b d=%h rdy=%b required 1 1 11 0",
                     frame_ok, m_if.tvalid, m_if.tdata, s_if.tready);
        end
        cycles(6);
        checks++;
        if (out_q.size() != 3) begin
            errors++;
            $display("FAIL good_count got %0d required 3", out_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_q[i] !== exp_d[i] || last_q[i] !== exp_l[i]) begin
                errors++;
                $display("FAIL good_byte[%0d] got %h/%b required %h/%b",
                         i, out_q[i], last_q[i], exp_d[i], exp_l[i]);
            end
        end
        checks++;
        if (ok_cnt != 1 || err_q.size() != 0 || drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL good_status got ok=%0d errs=%0d cnt=%0d required 1 0 0",
                     ok_cnt, err_q.size(), drop_cnt);
        end
    endtask

    task automatic test_bad_frames();
        clear_log();
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h98);
        checks++;
        if (frame_err !== 2'b01) begin
            errors++;
            $display("FAIL csum_err got %b required 01", frame_err);
        end
        cycles(1);
        checks++;
        if (frame_err !== 2'b00 || drop_cnt !== 8'd1) begin
            errors++;
            $display("FAIL csum_after got err=%b cnt=%0d required 00 1", frame_err, drop_cnt);
        end
        send_byte(8'hA5); send_byte(8'h00);
        checks++;
        if (frame_err !== 2'b10) begin
            errors++;
            $display("FAIL len_zero got %b required 10", frame_err);
        end
        send_byte(8'hA5); send_byte(8'h11);
        checks++;
        if (frame_err !== 2'b10) begin
            errors++;
            $display("FAIL len_over got %b required 10", frame_err);
        end
        cycles(2);
        checks++;
        if (drop_cnt !== 8'd3 || out_q.size() != 0 || ok_cnt != 0) begin
            errors++;
            $display("FAIL bad_summary got cnt=%0d out=%0d ok=%0d required 3 0 0",
                     drop_cnt, out_q.size(), ok_cnt);
        end
    endtask

    task automatic test_garbage_sync();
        clear_log();
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A); send_byte(8'hA5);
        send_byte(8'h02); send_byte(8'hA5); send_byte(8'h01); send_byte(8'h58);
        cycles(5);
        checks++;
        if (out_q.size() != 2 || out_q[0] !== 8'hA5 || out_q[1] !== 8'h01 ||
            last_q[0] !== 1'b0 || last_q[1] !== 1'b1) begin
            errors++;
            $display("FAIL data_sync got n=%0d %h/%b %h/%b required 2 a5/0 01/1",
                     out_q.size(), out_q[0], last_q[0], out_q[1], last_q[1]);
        end
        checks++;
        if (err_q.size() != 0 || drop_cnt !== 8'd3 || ok_cnt != 1) begin
            errors++;
            $display("FAIL garbage_status got errs=%0d cnt=%0d ok=%0d required 0 3 1",
                     err_q.size(), drop_cnt, ok_cnt);
        end
    endtask

    task automatic test_timeout();
        clear_log();
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
        rx_idle = 1'b1;
        cycles(1);
        checks++;
        if (frame_err !== 2'b11) begin
            errors++;
            $display("FAIL timeout_err got %b required 11", frame_err);
        end
        rx_idle = 1'b0;
        cycles(1);
        checks++;
        if (drop_cnt !== 8'd4) begin
            errors++;
            $display("FAIL timeout_cnt got %0d required 4", drop_cnt);
        end
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
        send_byte(8'h20); send_byte(8'hCE);
        cycles(4);
        checks++;
        if (out_q.size() != 2 || out_q[0] !== 8'h10 || out_q[1] !== 8'h20 ||
            last_q[1] !== 1'b1 || ok_cnt != 1) begin
            errors++;
            $display("FAIL timeout_next got n=%0d %h %h last=%b ok=%0d required 2 10 20 1 1",
                     out_q.size(), out_q[0], out_q[1], last_q[1], ok_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] prev_data;
        logic       prev_last;
        logic       prev_stall;
        int         hs;
        clear_log();
        m_if.tready = 1'b0;
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01);
        send_byte(8'h02); send_byte(8'h03); send_byte(8'h04); send_byte(8'hF2);
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        prev_last  = 1'b0;
        hs         = 0;
        for (int i = 0; i < 12; i++) begin
            m_if.tready = (i % 2 == 1);
            @(negedge aclk);
            if (prev_stall) begin
                checks++;
                if (m_if.tvalid !== 1'b1 || m_if.tdata !== prev_data ||
                    m_if.tlast !== prev_last) begin
                    errors++;
                    $display("FAIL stall_hold[%0d] got v=%b %h/%b required 1 %h/%b", i,
                             m_if.tvalid, m_if.tdata, m_if.tlast, prev_data, prev_last);
                end
            end
            if (m_if.tvalid) begin
                checks++;
                if (s_if.tready !== 1'b0) begin
                    errors++;
                    $display("FAIL drain_s_tready[%0d] got %b required 0", i, s_if.tready);
                end
            end
            if (m_if.tvalid && m_if.tready) hs++;
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_data  = m_if.tdata;
            prev_last  = m_if.tlast;
            @(posedge aclk);
            #1;
        end
        m_if.tready = 1'b1;
        checks++;
        if (hs != 4) begin
            errors++;
            $display("FAIL bp_handshakes got %0d required 4", hs);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_q[i] !== 8'(i + 1) || last_q[i] !== (i == 3)) begin
                errors++;
                $display("FAIL bp_byte[%0d] got %h/%b required %h/%b",
                         i, out_q[i], last_q[i], 8'(i + 1), (i == 3));
            end
        end
        checks++;
        if (s_if.tready !== 1'b1 || m_if.tvalid !== 1'b0) begin
            errors++;
            $display("FAIL bp_end got rdy=%b v=%b required 1 0", s_if.tready, m_if.tvalid);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 251; i++) begin
            send_byte(8'hA5); send_byte(8'h00);
        end
        cycles(1);
        checks++;
        if (drop_cnt !== 8'd255) begin
            errors++;
            $display("FAIL sat_reach got %0d required 255", drop_cnt);
        end
        for (int i = 0; i < 49; i++) begin
            send_byte(8'hA5); send_byte(8'h00);
        end
        cycles(1);
        checks++;
        if (drop_cnt !== 8'd255) begin
            errors++;
            $display("FAIL sat_hold got %0d required 255", drop_cnt);
        end
    endtask

    task automatic test_reset_drain();
        clear_log();
        m_if.tready = 1'b1;
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h0A);
        send_byte(8'h0B); send_byte(8'h0C); send_byte(8'h0D); send_byte(8'hCE);
        cycles(2);
        checks++;
        if (out_q.size() != 2 || m_if.tvalid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got n=%0d v=%b required 2 1", out_q.size(), m_if.tvalid);
        end
        aresetn = 1'b0;
        #1;
        checks++;
        if (m_if.tvalid !== 1'b0 || s_if.tready !== 1'b0 || drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL async_reset got v=%b rdy=%b cnt=%0d required 0 0 0",
                     m_if.tvalid, s_if.tready, drop_cnt);
        end
        cycles(2);
        aresetn = 1'b1;
        #1;
        checks++;
        if (s_if.tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_rdy got %b required 1", s_if.tready);
        end
        clear_log();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7F); send_byte(8'h80);
        cycles(3);
        checks++;
        if (out_q.size() != 1 || out_q[0] !== 8'h7F || last_q[0] !== 1'b1 ||
            ok_cnt != 1 || drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL post_reset got n=%0d %h/%b ok=%0d cnt=%0d required 1 7f/1 1 0",
                     out_q.size(), out_q[0], last_q[0], ok_cnt, drop_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_frames();
        test_garbage_sync();
        test_timeout();
        test_backpressure();
        test_saturate();
        test_reset_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
